log_capture_sequencer: RTL and testbench

- Sequences the equalizer log RAM controller.
- Accepts host commands (capture / readout / abort) and clears the RAM write-address counter before each capture.
- Gates write enable for exactly CAPTURE_LEN qualifying samples, then streams the stored words back out through a valid/ready port.
- Sits between the host register interface (GPIO/UART bridge) and the block RAM control block.

---
 rtl/log_pkg.sv | 23 ++
 rtl/log_readout_skid.sv | 37 +++
 rtl/log_capture_sequencer.sv | 165 ++++++++++++++++
 tb/tb_log_capture_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared opcodes, log-source selectors and sequencer states for the equalizer log path.
package log_pkg;

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_CAPTURE = 2'b01;
    localparam logic [1:0] CMD_READ    = 2'b10;
    localparam logic [1:0] CMD_ABORT   = 2'b11;

    localparam logic [2:0] SEL_FSE   = 3'b001;
    localparam logic [2:0] SEL_SLCR  = 3'b010;
    localparam logic [2:0] SEL_COEFF = 3'b011;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StCapture,
        StCaptured,
        StRdAddr,
        StRdWait,
        StRdHold
    } log_state_e;

endpackage

// File: rtl/log_readout_skid.sv
// Readout output register: captures the RAM word and holds it until the consumer takes it.
module log_readout_skid #(
    parameter int unsigned RAM_WIDTH = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_flush,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    input  logic                 i_rd_ready,
    output logic [RAM_WIDTH-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_handshake
);

    logic [RAM_WIDTH-1:0] data_q;
    logic                 valid_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (i_load) begin
            data_q  <= i_ram_data;
            valid_q <= 1'b1;
        end else if (valid_q && i_rd_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_rd_data   = data_q;
    assign o_rd_valid  = valid_q;
    assign o_handshake = valid_q && i_rd_ready;

endmodule

// File: rtl/log_capture_sequencer.sv
// Host-command sequencer for the equalizer log RAM: clear, gated capture, and paced readout.
module log_capture_sequencer
    import log_pkg::*;
#(
    parameter int unsigned RAM_WIDTH   = 32,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned CAPTURE_LEN = 32000,
    parameter int unsigned SEL_W       = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd_op,
    input  logic [SEL_W-1:0]     i_cmd_sel,
    input  logic                 i_enbl_rate_two,
    input  logic                 i_enbl_rate_one,
    input  logic                 i_coeff_strobe,
    output logic [SEL_W-1:0]     o_data_selec_for_log,
    output logic                 o_enbl_write,
    output logic                 o_enbl_read,
    output logic [ADDR_W-1:0]    o_read_adrs,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    output logic [RAM_WIDTH-1:0] o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic                 o_busy,
    output logic                 o_capture_done,
    output logic                 o_cmd_err,
    output logic [ADDR_W:0]      o_word_count
);

    localparam logic [ADDR_W:0] LenCnt = (ADDR_W + 1)'(CAPTURE_LEN);
    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    log_state_e          state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   adrs_q, adrs_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic cmd_abort, busy, sel_legal, strobe, handshake, last_word;

    assign cmd_abort = i_cmd_valid && (i_cmd_op == CMD_ABORT);
    assign busy      = !((state_q == StIdle) || (state_q == StCaptured));
    assign sel_legal = (i_cmd_sel == SEL_W'(SEL_FSE)) || (i_cmd_sel == SEL_W'(SEL_SLCR)) ||
                       (i_cmd_sel == SEL_W'(SEL_COEFF));
    assign last_word = ({1'b0, adrs_q} == (count_q - CntOne));

    always_comb begin
        strobe = 1'b0;
        if (sel_q == SEL_W'(SEL_FSE)) begin
            strobe = i_enbl_rate_two;
        end else if (sel_q == SEL_W'(SEL_SLCR)) begin
            strobe = i_enbl_rate_one;
        end else if (sel_q == SEL_W'(SEL_COEFF)) begin
            strobe = i_coeff_strobe;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        count_d = count_q;
        adrs_d  = adrs_q;
        done_d  = done_q;
        err_d   = 1'b0;
        if (cmd_abort) begin
            state_d = StIdle;
            count_d = '0;
            done_d  = 1'b0;
        end else begin
            if (i_cmd_valid && (i_cmd_op != CMD_NOP) && busy) begin
                err_d = 1'b1;
            end
            case (state_q)
                StIdle, StCaptured: begin
                    if (i_cmd_valid && (i_cmd_op == CMD_CAPTURE)) begin
                        if (sel_legal) begin
                            sel_d   = i_cmd_sel;
                            count_d = '0;
                            done_d  = 1'b0;
                            state_d = StClr;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (i_cmd_valid && (i_cmd_op == CMD_READ)) begin
                        if (count_q != '0) begin
                            adrs_d  = '0;
                            state_d = StRdAddr;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StClr:     state_d = StCapture;
                StCapture: begin
                    if (strobe) begin
                        count_d = count_q + CntOne;
                        if ((count_q + CntOne) == LenCnt) begin
                            done_d  = 1'b1;
                            state_d = StCaptured;
                        end
                    end
                end
                StRdAddr:  state_d = StRdWait;
                StRdWait:  state_d = StRdHold;
                StRdHold: begin
                    if (handshake) begin
                        if (last_word) begin
                            state_d = StCaptured;
                        end else begin
                            adrs_d  = adrs_q + 1'b1;
                            state_d = StRdAddr;
                        end
                    end
                end
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            count_q <= '0;
            adrs_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            count_q <= count_d;
            adrs_q  <= adrs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // RAM word for the address presented in RD_ADDR is valid during RD_WAIT.
    log_readout_skid #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_skid (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (state_q == StRdWait),
        .i_flush     (cmd_abort),
        .i_ram_data  (i_ram_data),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .o_handshake (handshake)
    );

    assign o_data_selec_for_log = sel_q;
    assign o_enbl_write         = (state_q == StCapture);
    assign o_enbl_read          = (state_q == StClr) || (state_q == StRdAddr);
    assign o_read_adrs          = adrs_q;
    assign o_busy               = busy;
    assign o_capture_done       = done_q;
    assign o_cmd_err            = err_q;
    assign o_word_count         = count_q;

endmodule

// File: tb/tb_log_capture_sequencer.sv
// Scoreboarded bench for log_capture_sequencer with a short capture length and a random RAM image.
module tb_log_capture_sequencer;

    localparam int RAM_WIDTH = 32;
    localparam int ADDR_W    = 15;
    localparam int LEN       = 16;
    localparam int SEL_W     = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic [1:0]           cmd_op = 2'b00;
    logic [SEL_W-1:0]     cmd_sel = '0;
    logic                 rate_two = 1'b0, rate_one = 1'b0, coeff = 1'b0;
    logic [SEL_W-1:0]     sel_out;
    logic                 enbl_write, enbl_read;
    logic [ADDR_W-1:0]    read_adrs;
    logic [RAM_WIDTH-1:0] ram_data = '0;
    logic [RAM_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready = 1'b0;
    logic                 busy, done, cmd_err;
    logic [ADDR_W:0]      word_count;

    log_capture_sequencer #(
        .RAM_WIDTH   (RAM_WIDTH),
        .ADDR_W      (ADDR_W),
        .CAPTURE_LEN (LEN),
        .SEL_W       (SEL_W)
    ) dut (
        .i_clock              (clk),
        .i_reset              (rst),
        .i_cmd_valid          (cmd_valid),
        .i_cmd_op             (cmd_op),
        .i_cmd_sel            (cmd_sel),
        .i_enbl_rate_two      (rate_two),
        .i_enbl_rate_one      (rate_one),
        .i_coeff_strobe       (coeff),
        .o_data_selec_for_log (sel_out),
        .o_enbl_write         (enbl_write),
        .o_enbl_read          (enbl_read),
        .o_read_adrs          (read_adrs),
        .i_ram_data           (ram_data),
        .o_rd_data            (rd_data),
        .o_rd_valid           (rd_valid),
        .i_rd_ready           (rd_ready),
        .o_busy               (busy),
        .o_capture_done       (done),
        .o_cmd_err            (cmd_err),
        .o_word_count         (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_words = 0;
    int ready_mode = 0;  // 0 low, 1 high, 2 random
    logic [RAM_WIDTH-1:0] mem [16];
    logic [RAM_WIDTH-1:0] exp_q [$];
    logic                 prev_stall = 1'b0;
    logic [RAM_WIDTH-1:0] prev_data = '0;

    // Synchronous-read RAM, one cycle latency, read only when enabled.
    always @(posedge clk) begin
        if (enbl_read) ram_data <= mem[read_adrs[3:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [SEL_W-1:0] sel);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_sel   = '0;
    endtask

    task automatic push_all;
        for (int a = 0; a < LEN; a++) exp_q.push_back(mem[a]);
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
        check(name, busy, 0);
    endtask

    // Monitor/scoreboard: pops one expected word per observed handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("write_read_exclusive", enbl_write && enbl_read, 0);
            if (prev_stall && rd_valid) check("hold_stable", rd_data, prev_data);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
                n_words++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rd_ready = 1'b0;
                1:       rd_ready = 1'b1;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, wcyc, expc, w0;
        for (int a = 0; a < 16; a++) mem[a] = $urandom;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_write", enbl_write, 0);
        check("rst_read", enbl_read, 0);
        check("rst_count", word_count, 0);
        check("rst_sel", sel_out, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Readout with nothing captured.
        cmd(2'b10, '0);
        check("read_empty_err", cmd_err, 1);
        check("read_empty_busy", busy, 0);

        // Capture FSE, strobe every second cycle; strobe during CLR must be ignored.
        cmd(2'b01, 3'b001);
        check("clr_read", enbl_read, 1);
        check("clr_write", enbl_write, 0);
        check("clr_err", cmd_err, 0);
        check("clr_sel", sel_out, 3'b001);
        rate_two = 1'b1;
        tick();
        wcyc = 0; expc = 0; k = 0;
        while (enbl_write && k < 200) begin
            wcyc++;
            rate_two = k[0];
            rate_one = 1'($urandom_range(0, 1));
            coeff    = 1'($urandom_range(0, 1));
            if (rate_two && expc < LEN) expc++;
            tick();
            check("fse_count", word_count, expc);
            k++;
        end
        rate_two = 0; rate_one = 0; coeff = 0;
        check("fse_write_cycles", wcyc, 2 * LEN);
        check("fse_done", done, 1);
        check("fse_final_count", word_count, LEN);
        check("fse_busy", busy, 0);

        // Full readout with random ready.
        ready_mode = 2;
        w0 = n_words;
        push_all();
        cmd(2'b10, '0);
        check("rd_start_err", cmd_err, 0);
        check("rd_addr_read", enbl_read, 1);
        wait_idle("rd1_finish", 2000);
        check("rd1_words", n_words - w0, LEN);
        check("rd1_queue", exp_q.size(), 0);
        check("rd1_done", done, 1);

        // Capture while reading is dropped; readout continues.
        w0 = n_words;
        push_all();
        cmd(2'b10, '0);
        repeat (4) tick();
        cmd(2'b01, 3'b001);
        check("cap_in_read_err", cmd_err, 1);
        check("cap_in_read_busy", busy, 1);
        wait_idle("rd2_finish", 2000);
        check("rd2_words", n_words - w0, LEN);
        check("rd2_queue", exp_q.size(), 0);

        // Illegal selector in CAPTURED.
        cmd(2'b01, 3'b100);
        check("bad_sel_err", cmd_err, 1);
        check("bad_sel_done", done, 1);
        check("bad_sel_busy", busy, 0);
        check("bad_sel_keep", sel_out, 3'b001);

        // Abort while holding word at address 3.
        w0 = n_words;
        push_all();
        cmd(2'b10, '0);
        k = 0;
        while (!(read_adrs == 3 && rd_valid) && k < 500) begin tick(); k++; end
        check("reach_adrs3", read_adrs == 3 && rd_valid, 1);
        cmd(2'b11, '0);
        exp_q.delete();
        check("abort_rd_busy", busy, 0);
        check("abort_rd_valid", rd_valid, 0);
        check("abort_rd_read", enbl_read, 0);
        check("abort_rd_done", done, 0);
        check("abort_rd_count", word_count, 0);
        check("abort_rd_err", cmd_err, 0);
        check("abort_rd_words", (n_words - w0 == 3) || (n_words - w0 == 4), 1);
        cmd(2'b10, '0);
        check("read_after_abort_err", cmd_err, 1);

        // Coefficient capture with rate strobes held high; abort at count 7.
        cmd(2'b01, 3'b011);
        check("coef_clr_read", enbl_read, 1);
        tick();
        rate_two = 1; rate_one = 1;
        expc = 0; k = 0;
        while (expc < 7 && k < 200) begin
            coeff = 1'($urandom_range(0, 1));
            if (coeff) expc++;
            tick();
            check("coef_count", word_count, expc);
            k++;
        end
        coeff = 1;
        cmd(2'b11, '0);
        check("abort_cap_busy", busy, 0);
        check("abort_cap_write", enbl_write, 0);
        check("abort_cap_count", word_count, 0);
        check("abort_cap_done", done, 0);

        // Restart: CLR pulse again, then full coefficient capture with a NOP inside.
        coeff = 0;
        cmd(2'b01, 3'b011);
        check("restart_clr_read", enbl_read, 1);
        check("restart_clr_write", enbl_write, 0);
        tick();
        expc = 0; k = 0;
        while (enbl_write && k < 300) begin
            coeff = 1'($urandom_range(0, 1));
            cmd_valid = (k == 3);
            if (coeff && expc < LEN) expc++;
            tick();
            cmd_valid = 0;
            check("coef2_count", word_count, expc);
            check("coef2_no_err", cmd_err, 0);
            k++;
        end
        coeff = 0;
        check("coef2_len", expc, LEN);
        check("coef2_done", done, 1);

        // Asynchronous reset in the middle of a capture.
        cmd(2'b01, 3'b010);
        tick();
        rate_one = 1;
        repeat (5) tick();
        check("pre_rst_count", word_count, 5);
        rst = 1'b1;
        #1;
        check("arst_write", enbl_write, 0);
        check("arst_read", enbl_read, 0);
        check("arst_busy", busy, 0);
        check("arst_count", word_count, 0);
        check("arst_sel", sel_out, 0);
        check("arst_adrs", read_adrs, 0);
        check("arst_done", done, 0);
        rate_one = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_count", word_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
